// File: rtl/ps2_key_src_pkg.sv
// Shared constants and types for the PS/2 keyboard source.
// Holds scan-code and ASCII constants plus the frame FSM state enum.
package ps2_key_src_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } frame_state_e;

  // Set-2 scan codes with special meaning
  localparam logic [7:0] ScBreak  = 8'hF0;
  localparam logic [7:0] ScExt    = 8'hE0;
  localparam logic [7:0] ScLShift = 8'h12;
  localparam logic [7:0] ScRShift = 8'h59;
  localparam logic [7:0] ScEnter  = 8'h5A;
  localparam logic [7:0] ScBksp   = 8'h66;
  localparam logic [7:0] ScSpace  = 8'h29;

  // ASCII codes for the non-printing / whitespace keys
  localparam logic [7:0] AsciiEnter = 8'd10;
  localparam logic [7:0] AsciiBs    = 8'd8;
  localparam logic [7:0] AsciiSpace = 8'd32;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 make-code to ASCII lookup.
// Ports:
//   scan_i   - make code byte
//   shift_i  - shift held; uppercases letters only
//   ascii_o  - translated ASCII code (0 when no hit)
//   hit_o    - scan code is mapped
module ps2_scan2ascii
  import ps2_key_src_pkg::*;
(
  input  logic [7:0] scan_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o,
  output logic       hit_o
);

  logic [7:0] code;
  logic       letter;

  always_comb begin
    code   = 8'h00;
    letter = 1'b0;
    hit_o  = 1'b1;
    case (scan_i)
      8'h1C: begin code = "a"; letter = 1'b1; end
      8'h32: begin code = "b"; letter = 1'b1; end
      8'h21: begin code = "c"; letter = 1'b1; end
      8'h23: begin code = "d"; letter = 1'b1; end
      8'h24: begin code = "e"; letter = 1'b1; end
      8'h2B: begin code = "f"; letter = 1'b1; end
      8'h34: begin code = "g"; letter = 1'b1; end
      8'h33: begin code = "h"; letter = 1'b1; end
      8'h43: begin code = "i"; letter = 1'b1; end
      8'h3B: begin code = "j"; letter = 1'b1; end
      8'h42: begin code = "k"; letter = 1'b1; end
      8'h4B: begin code = "l"; letter = 1'b1; end
      8'h3A: begin code = "m"; letter = 1'b1; end
      8'h31: begin code = "n"; letter = 1'b1; end
      8'h44: begin code = "o"; letter = 1'b1; end
      8'h4D: begin code = "p"; letter = 1'b1; end
      8'h15: begin code = "q"; letter = 1'b1; end
      8'h2D: begin code = "r"; letter = 1'b1; end
      8'h1B: begin code = "s"; letter = 1'b1; end
      8'h2C: begin code = "t"; letter = 1'b1; end
      8'h3C: begin code = "u"; letter = 1'b1; end
      8'h2A: begin code = "v"; letter = 1'b1; end
      8'h1D: begin code = "w"; letter = 1'b1; end
      8'h22: begin code = "x"; letter = 1'b1; end
      8'h35: begin code = "y"; letter = 1'b1; end
      8'h1A: begin code = "z"; letter = 1'b1; end
      8'h45: code = "0";
      8'h16: code = "1";
      8'h1E: code = "2";
      8'h26: code = "3";
      8'h25: code = "4";
      8'h2E: code = "5";
      8'h36: code = "6";
      8'h3D: code = "7";
      8'h3E: code = "8";
      8'h46: code = "9";
      ScSpace: code = AsciiSpace;
      ScEnter: code = AsciiEnter;
      ScBksp:  code = AsciiBs;
      default: hit_o = 1'b0;
    endcase
    // Lowercase and uppercase ASCII letters differ only in bit 5
    ascii_o = (letter && shift_i) ? (code & 8'hDF) : code;
  end

endmodule

// File: rtl/ps2_key_src.sv
// PS/2 keyboard receiver producing ASCII keypress strobes.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   ps2_clk   - raw keyboard clock (asynchronous)
//   ps2_data  - raw keyboard data (asynchronous)
//   key_in    - ASCII code of last accepted keypress
//   p_valid   - one-cycle strobe marking key_in valid
//   frame_err - one-cycle strobe on parity/stop/timeout error
//   shift_on  - high while either shift key is held
module ps2_key_src
  import ps2_key_src_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 5000,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       p_valid,
  output logic       frame_err,
  output logic       shift_on
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  frame_state_e           state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic [9:0]             frame_q, frame_d;
  logic                   brk_q, brk_d, ext_q, ext_d;
  logic                   lshift_q, lshift_d, rshift_q, rshift_d;
  logic [7:0]             key_q, key_d;
  logic                   p_valid_q, p_valid_d, frame_err_q, frame_err_d;

  logic       fall, data_s, frame_ok;
  logic [7:0] byte_s, ascii;
  logic       hit;

  // Index 0 is the newest sample, SYNC_STAGES-1 the oldest
  assign fall   = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Frame bits 7:0 data, 8 parity, 9 stop; odd parity over data+parity
  assign byte_s   = frame_q[7:0];
  assign frame_ok = (^frame_q[8:0]) & frame_q[9];
  assign shift_on = lshift_q | rshift_q;

  ps2_scan2ascii u_scan2ascii (
    .scan_i  (byte_s),
    .shift_i (shift_on),
    .ascii_o (ascii),
    .hit_o   (hit)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    wd_d        = wd_q;
    frame_d     = frame_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    key_d       = key_q;
    p_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = 4'd0;
        wd_d      = '0;
        if (fall && !data_s) state_d = StRecv;
      end
      StRecv: begin
        if (fall) begin
          frame_d = {data_s, frame_q[9:1]};
          wd_d    = '0;
          if (bit_cnt_q == 4'd9) state_d = StDone;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (wd_q == WdLast) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
        end else if (byte_s == ScBreak) begin
          brk_d = 1'b1;
        end else if (byte_s == ScExt) begin
          ext_d = 1'b1;
        end else begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (brk_q) begin
            if (byte_s == ScLShift) lshift_d = 1'b0;
            if (byte_s == ScRShift) rshift_d = 1'b0;
          end else if (!ext_q) begin
            if (byte_s == ScLShift) begin
              lshift_d = 1'b1;
            end else if (byte_s == ScRShift) begin
              rshift_d = 1'b1;
            end else if (hit) begin
              key_d     = ascii;
              p_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      wd_q        <= '0;
      frame_q     <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      key_q       <= 8'h00;
      p_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wd_q        <= wd_d;
      frame_q     <= frame_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      key_q       <= key_d;
      p_valid_q   <= p_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_in    = key_q;
  assign p_valid   = p_valid_q;
  assign frame_err = frame_err_q;

endmodule
